// File: rtl/mips_multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, control strobes and debug out.
interface mips_multicycle_control_unit_if #(
    parameter int unsigned ALU_CTRL_W = 3
);
    // Datapath -> control unit
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero_flag;
    logic                  mem_ready;

    // Control unit -> datapath
    logic                  pc_write;
    logic                  iord;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ALU_CTRL_W-1:0] alu_control;

    // Debug / status
    logic [3:0]            state;
    logic                  illegal_op;
    logic                  mem_timeout;

    // Control unit side
    modport master (
        input  opcode, funct, zero_flag, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
               state, illegal_op, mem_timeout
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero_flag, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
               state, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mips_multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM driving the shared-memory datapath,
// with a memory-wait watchdog and a sticky unsupported-instruction flag.
// Optional feature: define MIPS_CU_BNE_EN to add bne (opcode 000101) through the BRANCH state.
module mips_multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    mips_multicycle_control_unit_if.master cu_bus
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CU_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_illegal;
    logic              r_mem_timeout;
    logic              r_is_sw;
`ifdef MIPS_CU_BNE_EN
    logic              r_is_bne;
`endif

    logic              w_wait_state;
    logic              w_wait_inc;
    logic              w_timeout;
    logic              w_set_illegal;
    logic              w_funct_ok;
    logic [2:0]        w_funct_alu;
    logic              w_branch_take;

    logic              w_pc_write;
    logic              w_iord;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_ir_write;
    logic              w_mem_to_reg;
    logic              w_reg_dst;
    logic              w_reg_write;
    logic              w_alu_src_a;
    logic [1:0]        w_alu_src_b;
    logic [1:0]        w_pc_src;
    logic [2:0]        w_alu_op;

    // Watchdog: a memory-wait state with mem_ready low either keeps counting or aborts.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout    = w_wait_state && !cu_bus.mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_wait_inc   = w_wait_state && !cu_bus.mem_ready && !w_timeout;

`ifdef MIPS_CU_BNE_EN
    assign w_branch_take = r_is_bne ? ~cu_bus.zero_flag : cu_bus.zero_flag;
`else
    assign w_branch_take = cu_bus.zero_flag;
`endif

    // R-type funct decode into ALU operation plus a supported flag.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (cu_bus.funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // State register; reset lands in FETCH regardless of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; unsupported opcodes/functs fall back to FETCH and flag illegal.
    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_timeout) begin
                    w_state_next = S_FETCH;
                end else if (cu_bus.mem_ready) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cu_bus.opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_EXEC;
                    OP_BEQ:       w_state_next = S_BRANCH;
`ifdef MIPS_CU_BNE_EN
                    OP_BNE:       w_state_next = S_BRANCH;
`endif
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JUMP;
                    default: begin
                        w_state_next  = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_state_next = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (w_timeout) begin
                    w_state_next = S_FETCH;
                end else if (cu_bus.mem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (w_timeout || cu_bus.mem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_MEMWB:  w_state_next = S_FETCH;
            S_EXEC: begin
                if (w_funct_ok) begin
                    w_state_next = S_ALUWB;
                end else begin
                    w_state_next  = S_FETCH;
                    w_set_illegal = 1'b1;
                end
            end
            S_ALUWB:  w_state_next = S_FETCH;
            S_BRANCH: w_state_next = S_FETCH;
            S_ADDIEX: w_state_next = S_ADDIWB;
            S_ADDIWB: w_state_next = S_FETCH;
            S_JUMP:   w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // Moore outputs per state; FETCH strobes only fire on the mem_ready cycle and never in reset.
    always_comb begin
        w_pc_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_alu_op     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = cu_bus.mem_ready & ~rst;
                w_pc_write  = cu_bus.mem_ready & ~rst;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = w_funct_alu;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = ALU_SUB;
                w_pc_src    = 2'b01;
                w_pc_write  = w_branch_take;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Wait counter, sticky illegal flag, abort pulse and load/store direction capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_illegal     <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_is_sw       <= 1'b0;
        end else begin
            r_wait_cnt    <= w_wait_inc ? r_wait_cnt + WAIT_W'(1) : '0;
            r_mem_timeout <= w_timeout;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (r_state == S_DECODE) begin
                r_is_sw <= (cu_bus.opcode == OP_SW);
            end
        end
    end

`ifdef MIPS_CU_BNE_EN
    // Remember whether the branch in flight is bne so BRANCH inverts the zero test.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_bne <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_is_bne <= (cu_bus.opcode == OP_BNE);
        end
    end
`endif

    assign cu_bus.pc_write    = w_pc_write;
    assign cu_bus.iord        = w_iord;
    assign cu_bus.mem_read    = w_mem_read;
    assign cu_bus.mem_write   = w_mem_write;
    assign cu_bus.ir_write    = w_ir_write;
    assign cu_bus.mem_to_reg  = w_mem_to_reg;
    assign cu_bus.reg_dst     = w_reg_dst;
    assign cu_bus.reg_write   = w_reg_write;
    assign cu_bus.alu_src_a   = w_alu_src_a;
    assign cu_bus.alu_src_b   = w_alu_src_b;
    assign cu_bus.pc_src      = w_pc_src;
    assign cu_bus.alu_control = ALU_CTRL_W'(w_alu_op);
    assign cu_bus.state       = r_state;
    assign cu_bus.illegal_op  = r_illegal;
    assign cu_bus.mem_timeout = r_mem_timeout;

endmodule
